// File: rtl/stepper_move_sequencer.sv
// stepper_move_sequencer: queued step/dir motion controller behind a local-bus register window
module stepper_move_sequencer #(
    parameter int PERIOD_W   = 16,
    parameter int STEPS_W    = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int DIR_SETUP  = 4
) (
    input  logic        LClk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [2:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        st_clk,
    output logic        st_dir,
    output logic        st_enb,
    output logic        busy,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 1 + STEPS_W + PERIOD_W;
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
    typedef enum logic [2:0] {IDLE, LOAD, SETUP, HIGH, LOW, HOLD} state_t;
    state_t state;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [EW-1:0] cmd;
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic [PERIOD_W-1:0] period_reg, hp, tmr;
    logic [STEPS_W-1:0] remaining;
    logic enable, done, ovf, aborted;
    logic empty, full, push, pop, push_ok, abort, eoc, tmr_last, done_set;
    logic clr_done, clr_err, unused_wr;
    logic [31:0] status;
    assign st_enb = enable;
    assign irq = done;
    assign busy = state != IDLE;
    assign unused_wr = ^wr_data;
    assign empty = cnt == '0;
    assign full = cnt == DEPTH_C;
    assign abort = wr_en && wr_addr == 3'd2 && wr_data[1];
    assign clr_done = wr_en && wr_addr == 3'd2 && wr_data[2];
    assign clr_err = wr_en && wr_addr == 3'd2 && wr_data[3];
    assign push = wr_en && wr_addr == 3'd1;
    assign tmr_last = tmr == PERIOD_W'(1);
    // end of command: a zero-step command in LOAD, or the last LOW cycle of the final step
    assign eoc = (state == LOAD && cmd[PERIOD_W +: STEPS_W] == '0) ||
                 (state == LOW && tmr_last && remaining == STEPS_W'(1));
    assign pop = !abort && enable && !empty && (state == IDLE || eoc);
    assign push_ok = push && !abort && (!full || pop);
    assign done_set = !abort && eoc && !pop && empty;
    always_comb begin
        status = '0;
        status[5:0] = {aborted, ovf, done, full, empty, busy};
        status[10:8] = 3'(cnt);
    end
    always_ff @(posedge LClk)
        if (push_ok) mem[wp] <= {wr_data[31], wr_data[STEPS_W-1:0], period_reg};
    always_ff @(posedge LClk) begin
        if (!rst) begin
            state <= IDLE;
            cmd <= '0;
            wp <= '0;
            rp <= '0;
            cnt <= '0;
            period_reg <= PERIOD_W'(1);
            hp <= PERIOD_W'(1);
            tmr <= '0;
            remaining <= '0;
            enable <= 1'b0;
            done <= 1'b0;
            ovf <= 1'b0;
            aborted <= 1'b0;
            st_clk <= 1'b0;
            st_dir <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_data <= rd_addr == 3'd0 ? 32'(period_reg) :
                       rd_addr == 3'd3 ? status :
                       rd_addr == 3'd4 ? 32'(remaining) : '0;
            if (wr_en && wr_addr == 3'd0)
                period_reg <= wr_data[PERIOD_W-1:0] == '0 ? PERIOD_W'(1) : wr_data[PERIOD_W-1:0];
            if (wr_en && wr_addr == 3'd2) enable <= wr_data[0];
            done <= done_set || (done && !clr_done);
            ovf <= (push && !abort && full && !pop) || (ovf && !clr_err);
            aborted <= abort || (aborted && !clr_err);
            if (abort) begin
                wp <= '0;
                rp <= '0;
                cnt <= '0;
            end else begin
                if (push_ok) wp <= wp + 1'b1;
                if (pop) begin
                    cmd <= mem[rp];
                    rp <= rp + 1'b1;
                end
                cnt <= cnt + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
            end
            if (abort) begin
                state <= IDLE;
                st_clk <= 1'b0;
                remaining <= '0;
            end else begin
                case (state)
                    IDLE: if (pop) state <= LOAD;
                    LOAD: begin
                        st_dir <= cmd[EW-1];
                        hp <= cmd[PERIOD_W-1:0];
                        remaining <= cmd[PERIOD_W +: STEPS_W];
                        tmr <= PERIOD_W'(DIR_SETUP);
                        state <= eoc ? (pop ? LOAD : IDLE) : SETUP;
                    end
                    SETUP: begin
                        tmr <= tmr_last ? hp : tmr - 1'b1;
                        if (tmr_last) begin
                            state <= HIGH;
                            st_clk <= 1'b1;
                        end
                    end
                    HIGH: begin
                        tmr <= tmr_last ? hp : tmr - 1'b1;
                        if (tmr_last) begin
                            state <= LOW;
                            st_clk <= 1'b0;
                        end
                    end
                    LOW: begin
                        tmr <= tmr_last ? hp : tmr - 1'b1;
                        if (tmr_last) begin
                            remaining <= remaining - 1'b1;
                            st_clk <= !eoc && enable;
                            state <= eoc ? (pop ? LOAD : IDLE) : (enable ? HIGH : HOLD);
                        end
                    end
                    HOLD: if (enable) begin
                        state <= HIGH;
                        st_clk <= 1'b1;
                        tmr <= hp;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_stepper_move_sequencer.sv
// tb_stepper_move_sequencer: scoreboard bench checking register reads and step pulse timing
module tb_stepper_move_sequencer;
    logic LClk = 1'b0, rst = 1'b0, wr_en = 1'b0;
    logic [2:0] wr_addr = '0, rd_addr = '0;
    logic [31:0] wr_data = '0, rd_data;
    logic st_clk, st_dir, st_enb, busy, irq;
    int tests = 0, fails = 0, cyc = 0;
    logic rd_req = 1'b0, rd_req_q = 1'b0;
    typedef struct {string name; logic [31:0] exp;} rd_exp_t;
    typedef struct {int width; int gap; int rise_at; logic dir;} pulse_t;
    rd_exp_t rq[$];
    pulse_t pq[$];
    rd_exp_t re;
    pulse_t cur;
    logic have_cur = 1'b0, clk_q = 1'b0;
    int hi_cnt = 0, lo_cnt = 0;

    stepper_move_sequencer dut (
        .LClk(LClk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .st_clk(st_clk), .st_dir(st_dir),
        .st_enb(st_enb), .busy(busy), .irq(irq)
    );

    always #5 LClk = ~LClk;
    always @(posedge LClk) begin
        cyc <= cyc + 1;
        rd_req_q <= rd_req;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge LClk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
        rd_exp_t x;
        x.name = n;
        x.exp = e;
        rq.push_back(x);
        rd_addr = a;
        rd_req = 1'b1;
        @(negedge LClk);
        rd_req = 1'b0;
    endtask

    task automatic ep(input int w, input int g, input int r, input logic d);
        pulse_t x;
        x.width = w;
        x.gap = g;
        x.rise_at = r;
        x.dir = d;
        pq.push_back(x);
    endtask

    task automatic wait_idle(input string n);
        int k = 0;
        repeat (3) @(negedge LClk);
        while (busy && k < 2000) begin
            @(negedge LClk);
            k++;
        end
        tests++;
        if (busy) begin
            fails++;
            $display("FAIL %s: busy still 1 after %0d cycles, expected 0", n, k);
        end
    endtask

    task automatic wait_rises(input int n, input string nm);
        int seen = 0;
        int k = 0;
        logic p;
        p = st_clk;
        while (seen < n && k < 5000) begin
            @(negedge LClk);
            k++;
            if (st_clk && !p) seen++;
            p = st_clk;
        end
        if (seen < n) begin
            tests++;
            fails++;
            $display("FAIL %s: saw %0d rising edges, expected %0d", nm, seen, n);
        end
    endtask

    initial forever begin
        @(negedge LClk);
        if (rd_req_q) begin
            if (rq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_unexpected: read data 0x%0h with no expectation queued", rd_data);
            end else begin
                re = rq.pop_front();
                chk(re.name, rd_data, re.exp);
            end
        end
    end

    initial forever begin
        @(negedge LClk);
        if (st_clk && !clk_q) begin
            if (pq.size() == 0) begin
                tests++;
                fails++;
                have_cur = 1'b0;
                $display("FAIL pulse_unexpected: rise at cycle %0d, expected none", cyc);
            end else begin
                cur = pq.pop_front();
                have_cur = 1'b1;
                chk("pulse_dir", st_dir, cur.dir);
                if (cur.gap >= 0) chk("pulse_gap", lo_cnt, cur.gap);
                if (cur.rise_at >= 0) chk("pulse_rise_cycle", cyc, cur.rise_at);
            end
            hi_cnt = 0;
        end
        if (!st_clk && clk_q) begin
            if (have_cur) chk("pulse_width", hi_cnt, cur.width);
            lo_cnt = 0;
        end
        if (st_clk) hi_cnt++;
        else lo_cnt++;
        clk_q = st_clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w;
        repeat (3) @(negedge LClk);
        chk("rst_st_clk", st_clk, 0);
        chk("rst_st_dir", st_dir, 0);
        chk("rst_st_enb", st_enb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_irq", irq, 0);
        chk("rst_rd_data", rd_data, 0);
        rst = 1'b1;
        rd(3'd0, 32'h1, "period_after_reset");
        rd(3'd3, 32'h2, "status_after_reset");
        wr(3'd0, 32'h0);
        rd(3'd0, 32'h1, "period_zero_stored_as_one");

        wr(3'd2, 32'h1);
        chk("enable_pin", st_enb, 1);
        wr(3'd0, 32'd3);
        rd(3'd0, 32'd3, "period_readback");
        wr(3'd1, 32'h8000_0002);
        w = cyc;
        ep(3, -1, w + 6, 1'b1);
        ep(3, 3, -1, 1'b1);
        wait_idle("t1_idle");
        rd(3'd3, 32'hA, "t1_status_done");
        chk("t1_irq", irq, 1);
        rd(3'd4, 32'h0, "t1_remaining");
        wr(3'd2, 32'h5);
        rd(3'd3, 32'h2, "t1_done_cleared");

        wr(3'd2, 32'h0);
        wr(3'd0, 32'd2);
        for (int i = 0; i < 5; i++) wr(3'd1, {i[0], 31'd1});
        rd(3'd3, 32'h414, "t2_full_overflow");
        wr(3'd2, 32'h1);
        w = cyc;
        ep(2, -1, w + 6, 1'b0);
        ep(2, 7, -1, 1'b1);
        ep(2, 7, -1, 1'b0);
        ep(2, 7, -1, 1'b1);
        repeat (10) @(negedge LClk);
        chk("t2_no_early_done", irq, 0);
        wait_idle("t2_idle");
        rd(3'd3, 32'h1A, "t2_done_after_four");
        wr(3'd2, 32'hD);
        rd(3'd3, 32'h2, "t2_flags_cleared");

        wr(3'd0, 32'd1);
        wr(3'd1, 32'h0);
        wr(3'd1, 32'h8000_0001);
        w = cyc;
        ep(1, -1, w + 6, 1'b1);
        wait_idle("t3_idle");
        rd(3'd3, 32'hA, "t3_done");
        wr(3'd2, 32'h5);

        wr(3'd0, 32'd10);
        wr(3'd1, 32'd100);
        w = cyc;
        ep(4, -1, w + 6, 1'b0);
        wait_rises(1, "t4_rise");
        repeat (3) @(negedge LClk);
        wr(3'd2, 32'h3);
        chk("t4_busy", busy, 0);
        chk("t4_st_clk", st_clk, 0);
        rd(3'd3, 32'h22, "t4_status_aborted");
        rd(3'd4, 32'h0, "t4_remaining");
        wr(3'd2, 32'h9);
        rd(3'd3, 32'h2, "t4_aborted_cleared");

        wr(3'd0, 32'd2);
        wr(3'd1, 32'd10);
        w = cyc;
        ep(2, -1, w + 6, 1'b0);
        ep(2, 2, -1, 1'b0);
        ep(2, 2, -1, 1'b0);
        wait_rises(3, "t5_three_pulses");
        wr(3'd2, 32'h0);
        repeat (8) @(negedge LClk);
        chk("t5_hold_low", st_clk, 0);
        rd(3'd4, 32'd7, "t5_remaining_hold");
        rd(3'd3, 32'h3, "t5_status_hold");
        for (int i = 0; i < 7; i++) ep(2, i == 0 ? -1 : 2, i == 0 ? cyc + 2 : -1, 1'b0);
        wr(3'd2, 32'h1);
        wait_idle("t5_idle");
        rd(3'd3, 32'hA, "t5_done");
        wr(3'd2, 32'h5);

        wr(3'd0, 32'd4);
        wr(3'd1, 32'h8000_0005);
        w = cyc;
        wr(3'd1, 32'h8000_0005);
        wr(3'd1, 32'h8000_0005);
        ep(2, -1, w + 6, 1'b1);
        wait_rises(1, "t6_rise");
        @(negedge LClk);
        rst = 1'b0;
        @(negedge LClk);
        chk("t6_st_clk", st_clk, 0);
        chk("t6_st_dir", st_dir, 0);
        chk("t6_st_enb", st_enb, 0);
        chk("t6_busy", busy, 0);
        chk("t6_irq", irq, 0);
        chk("t6_rd_data", rd_data, 0);
        @(negedge LClk);
        rst = 1'b1;
        rd(3'd3, 32'h2, "t6_status_empty");
        rd(3'd0, 32'h1, "t6_period");

        repeat (20) @(negedge LClk);
        chk("pulses_left", pq.size(), 0);
        chk("reads_left", rq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/stepper_move_sequencer.md
Name: stepper_move_sequencer

Overview:
- Queued stepper-motion controller on the 5i20 local-bus register window.
- The host stages a half-period, then pushes move commands (direction plus step count) into a small command FIFO.
- The sequencer pops each command and drives st_dir and st_clk through a fixed direction-setup delay and an exact number of step pulses.
- It reports busy, FIFO state and sticky done/overflow/abort flags back to the host.

Parameters:
- PERIOD_W, 16, width of the half-period in LClk cycles.
- STEPS_W, 24, width of the step count.
- FIFO_DEPTH, 4, command FIFO entries; must be a power of 2, minimum 2.
- DIR_SETUP, 4, LClk cycles st_dir is held with st_clk low before the first pulse of each command; minimum 1.

Ports:
- LClk  in  1  clock; all logic is on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- wr_en  in  1  single-cycle register write strobe.
- wr_addr  in  3  register select for writes.
- wr_data  in  32  write data.
- rd_addr  in  3  register select for reads.
- rd_data  out  32  registered read data, 1-cycle latency.
- st_clk  out  1  step pulse output.
- st_dir  out  1  direction output.
- st_enb  out  1  driver enable; equals CTRL.enable.
- busy  out  1  high in any state other than IDLE.
- irq  out  1  equals the done sticky flag.

Behaviour:
- Reset (rst=0 at a clock edge): all outputs are 0; FIFO is emptied; period register=1; state=IDLE; all sticky flags=0.
- Write registers:
  - addr0 PERIOD: period_reg <= wr_data[PERIOD_W-1:0]; a written value of 0 is stored as 1.
  - addr1 PUSH: pushes {dir=wr_data[31], steps=wr_data[STEPS_W-1:0], period_reg} into the FIFO.
  - addr2 CTRL: bit0=enable (level); bit1=abort (one-shot); bit2=clear done; bit3=clear overflow/aborted.
  - Other addresses: writes are ignored.
- Read registers:
  - addr0: period_reg.
  - addr3 STATUS: bit0 busy, bit1 empty, bit2 full, bit3 done, bit4 overflow, bit5 aborted, bits[10:8] fifo count (0..FIFO_DEPTH).
  - addr4: remaining steps of the current command.
  - Other addresses: read as 0.
- FIFO:
  - Push while full is dropped and sets overflow.
  - Push and pop in the same cycle are both performed, so the count is unchanged; this is legal even when full.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, LOAD, SETUP, HIGH, LOW, HOLD.
- IDLE:
  - When enable=1 and the FIFO is not empty: pop; next state LOAD.
  - st_clk=0.
- LOAD (1 cycle):
  - Latch the command; st_dir <= dir; hp <= period.
  - If steps=0: the command is discarded, with no pulses and no SETUP; go to end-of-command handling.
  - Otherwise go to SETUP with its counter = DIR_SETUP.
- SETUP: st_clk=0 for exactly DIR_SETUP cycles, then HIGH.
- HIGH: st_clk=1 for exactly hp cycles, then LOW.
- LOW:
  - st_clk=0 for exactly hp cycles; remaining decrements on the last LOW cycle.
  - If remaining becomes 0: end-of-command.
  - Else if enable=1: HIGH.
  - Else: HOLD.
- HOLD: st_clk=0 until enable=1, then HIGH. No additional SETUP is inserted.
- End-of-command:
  - If enable=1 and the FIFO is not empty: pop in the same cycle and go to LOAD.
  - Otherwise go to IDLE.
  - done sets when the IDLE transition happens with the FIFO empty.
- Resulting step period is 2*hp cycles.
- First rising edge of st_clk is 2+DIR_SETUP cycles after the PUSH write when idle, enabled and the FIFO is empty (1 cycle push, 1 IDLE pop, 1 LOAD, then SETUP).
- Abort:
  - From any state: next cycle state=IDLE, st_clk=0, FIFO flushed, remaining=0, aborted=1, done unchanged.
  - st_dir holds its last value.
  - Abort wins over a simultaneous push, which is dropped without setting overflow.
- Sticky flags: a set and its clear in the same cycle → set wins.
- Clearing enable: takes effect at the next LOW-phase boundary (HOLD) or blocks the pop in IDLE. A HIGH phase is never truncated.
- PERIOD writes affect only subsequently pushed commands.
- Reset mid-move: identical to the reset values above, with the clock stopping low on the next edge.

Test Plan:
1. Enable=1, PERIOD=3, PUSH dir=1 steps=2 → st_dir=1 at cycle 3 after the write. st_clk high at cycles 3+DIR_SETUP..+2 and +6..+8 (3 high, 3 low each). busy falls after the final LOW phase; done=1; irq=1.
2. PUSH 5 commands with enable=0, FIFO_DEPTH=4 → status full=1, count=4, overflow=1. Enable → 4 commands execute back-to-back, each with a SETUP gap; done sets only after the 4th.
3. PUSH steps=0, then PUSH steps=1 period=1 → first command produces no pulse. Exactly 1 pulse, 1 cycle wide, then done.
4. Mid-move (steps=100, PERIOD=10), write abort during HIGH → st_clk=0 next cycle, busy=0, empty=1, aborted=1, remaining reads 0.
5. During steps=10, clear enable after pulse 3 → st_clk stays low with remaining=7 in HOLD; re-enable → exactly 7 more pulses, no SETUP delay.
6. Assert rst=0 during HIGH with 2 FIFO entries queued → all outputs 0, status reads empty, PERIOD reads 1.
